// File: rtl/rv_fetch_pkg.sv
// Shared definitions for the instruction-fetch front end: fetch FSM states
// and the architectural widths used by the PC register.
package rv_fetch_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    // Byte-offset bits below instruction granularity; these must be zero in a legal PC.
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSTR_BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_FAULT
    } fetch_state_e;

endpackage

// File: rtl/ifetch_pc_reg.sv
// Architectural PC register and single-outstanding instruction fetch front end.
// Define IFETCH_MISALIGN_CHECK_EN to trap misaligned next-PC targets into a sticky FAULT state.
module ifetch_pc_reg
    import rv_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            pc_load,
    input  logic [XLEN-1:0] next_pc,
    output logic            fetch_fault,
    output logic [XLEN-1:0] retired_count
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic [XLEN-1:0] retired_q, retired_d;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        retired_d  = retired_q;

        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                if (imem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    instr_d    = imem_rsp_data;
                    instr_pc_d = pc_q;
                    state_d    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (pc_load) begin
                    retired_d = retired_q + 32'd1;
`ifdef IFETCH_MISALIGN_CHECK_EN
                    // A faulting target still retires the instruction but leaves pc untouched.
                    if ((next_pc & ALIGN_MASK) != '0) begin
                        state_d = ST_FAULT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = ST_REQ;
                    end
`else
                    pc_d    = next_pc & ~ALIGN_MASK;
                    state_d = ST_REQ;
`endif
                end
            end
`ifdef IFETCH_MISALIGN_CHECK_EN
            ST_FAULT: state_d = ST_FAULT;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            retired_q  <= retired_d;
        end
    end

    // Every output comes straight from a flop or a state decode, never from an input.
    assign imem_req_valid = (state_q == ST_REQ);
    assign imem_req_addr  = pc_q;
    assign instr_valid    = (state_q == ST_HOLD);
    assign instr          = instr_q;
    assign instr_pc       = instr_pc_q;
    assign retired_count  = retired_q;
`ifdef IFETCH_MISALIGN_CHECK_EN
    assign fetch_fault    = (state_q == ST_FAULT);
`else
    assign fetch_fault    = 1'b0;
`endif

endmodule
